// File: rtl/stopwatch.sv
// rtl/stopwatch.sv - free-running HH:MM:SS.cc BCD stopwatch driving an 8-digit multiplexed display
//
// Purpose: counts centiseconds from reset as a cascaded BCD chain (cs0,cs1,s0,s1,m0,m1,h0,h1)
//          and scans the eight digits onto a common-anode seven-segment display.
// Ports:
//   clk_in  - system clock, all state on its rising edge
//   rst     - synchronous active-high reset
//   AN[7:0] - anode selects, active-low, one-hot-low (index 0 = cs0 ... index 7 = h1)
//   CAT[6:0]- segment cathodes, active-low, CAT[0]=a ... CAT[6]=g
module stopwatch #(
    parameter int TICK_DIV    = 1_000_000,
    parameter int REFRESH_DIV = 100_000
) (
    input  logic       clk_in,
    input  logic       rst,
    output logic [7:0] AN,
    output logic [6:0] CAT
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    localparam logic [6:0] GLYPH_ZERO = 7'b1000000;

    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [RW-1:0] ref_cnt_q, ref_cnt_d;
    logic [2:0]    idx_q, idx_d;
    // Packed digits, nibble i holds display index i (cs0 in [3:0] ... h1 in [31:28]).
    logic [31:0]   dig_q, dig_d;
    logic [7:0]    an_q, an_d;
    logic [6:0]    cat_q, cat_d;

    logic          tick;
    logic          ref_wrap;
    logic          carry;
    logic [3:0]    sel_digit;

    // Tens-of-seconds and tens-of-minutes wrap at 5; every other digit wraps at 9.
    function automatic logic [3:0] digit_max(input int i);
        return ((i == 3) || (i == 5)) ? 4'd5 : 4'd9;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    always_comb begin
        tick       = (tick_cnt_q == TW'(TICK_DIV - 1));
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

        ref_wrap  = (ref_cnt_q == RW'(REFRESH_DIV - 1));
        ref_cnt_d = ref_wrap ? '0 : ref_cnt_q + 1'b1;
        idx_d     = ref_wrap ? idx_q + 3'd1 : idx_q;

        // Ripple the tick up the chain: a digit that wraps passes the carry on,
        // the first digit that merely increments absorbs it.
        dig_d = dig_q;
        carry = tick;
        for (int i = 0; i < 8; i++) begin
            if (carry) begin
                if (dig_q[4*i +: 4] == digit_max(i)) begin
                    dig_d[4*i +: 4] = 4'd0;
                end else begin
                    dig_d[4*i +: 4] = dig_q[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end

        // Outputs are built from the current index/digits, so they lag by one cycle.
        sel_digit = dig_q[{idx_q, 2'b00} +: 4];
        an_d      = ~(8'b0000_0001 << idx_q);
        cat_d     = seg_decode(sel_digit);
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            tick_cnt_q <= '0;
            ref_cnt_q  <= '0;
            idx_q      <= 3'd0;
            dig_q      <= 32'd0;
            an_q       <= 8'hFE;
            cat_q      <= GLYPH_ZERO;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            ref_cnt_q  <= ref_cnt_d;
            idx_q      <= idx_d;
            dig_q      <= dig_d;
            an_q       <= an_d;
            cat_q      <= cat_d;
        end
    end

    assign AN  = an_q;
    assign CAT = cat_q;

endmodule

// File: tb/tb_stopwatch.sv
// tb/tb_stopwatch.sv - self-checking bench for stopwatch with a centisecond-count reference model
module tb_stopwatch;

    localparam int TD     = 4;
    localparam int RD     = 2;
    localparam int CS_MAX = 36_000_000;

    logic       clk_in;
    logic       rst;
    logic [7:0] AN;
    logic [6:0] CAT;

    stopwatch #(.TICK_DIV(TD), .REFRESH_DIV(RD)) dut (
        .clk_in(clk_in),
        .rst   (rst),
        .AN    (AN),
        .CAT   (CAT)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    // Reference model: elapsed time as one integer count of centiseconds.
    bit         m_valid = 1'b0;
    int         m_n     = 0;
    int         m_cs    = 0;
    logic [7:0] exp_an;
    logic [6:0] exp_cat;
    logic [31:0] pre_bcd;

    logic [6:0] glyph [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    function automatic int digit_of(input int cs, input int idx);
        case (idx)
            0:       return cs % 10;
            1:       return (cs / 10) % 10;
            2:       return (cs / 100) % 10;
            3:       return (cs / 1000) % 6;
            4:       return (cs / 6000) % 10;
            5:       return (cs / 60000) % 6;
            6:       return (cs / 360000) % 10;
            default: return (cs / 3600000) % 10;
        endcase
    endfunction

    function automatic logic [31:0] to_bcd(input int cs);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r[4*i +: 4] = 4'(digit_of(cs, i));
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One clock: advance the model at the rising edge, compare outputs at the falling edge.
    task automatic step();
        int idx;
        @(posedge clk_in);
        if (rst) begin
            m_valid = 1'b1;
            m_n     = 0;
            m_cs    = 0;
            exp_an  = 8'hFE;
            exp_cat = glyph[0];
        end else if (m_valid) begin
            idx     = (m_n / RD) % 8;
            exp_an  = ~(8'b1 << idx);
            exp_cat = glyph[digit_of(m_cs, idx)];
            m_n++;
            if (m_n % TD == 0) m_cs = (m_cs + 1) % CS_MAX;
        end
        @(negedge clk_in);
        if (m_valid) begin
            chk("an_model", {24'd0, AN}, {24'd0, exp_an});
            chk("cat_model", {25'd0, CAT}, {25'd0, exp_cat});
            chk("an_onehot", $countones(~AN), 1);
        end
    endtask

    task automatic preload(input int cs);
        pre_bcd = to_bcd(cs);
        force dut.dig_q = pre_bcd;
        #1;
        release dut.dig_q;
        m_cs = cs;
    endtask

    logic [7:0] scan_exp [17] = '{8'hFE, 8'hFE, 8'hFD, 8'hFD, 8'hFB, 8'hFB, 8'hF7, 8'hF7,
                                  8'hEF, 8'hEF, 8'hDF, 8'hDF, 8'hBF, 8'hBF, 8'h7F, 8'h7F, 8'hFE};

    initial begin
        bit seen;
        rst = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            chk("reset_an", {24'd0, AN}, 32'h0000_00FE);
            chk("reset_cat", {25'd0, CAT}, 32'h0000_0040);
        end
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            step();
            chk("scan_an", {24'd0, AN}, {24'd0, scan_exp[i]});
        end
        for (int i = 17; i < 100; i++) step();
        chk("cs_after_100", dut.dig_q, 32'h0000_0025);
        chk("model_cs_25", m_cs, 25);

        preload(5999);
        for (int i = 0; i < 4; i++) step();
        chk("wrap_minute", dut.dig_q, 32'h0001_0000);
        chk("model_6000", m_cs, 6000);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (!seen && AN == 8'hEF) begin
                seen = 1'b1;
                chk("m0_glyph_one", {25'd0, CAT}, 32'h0000_0079);
            end
        end
        if (!seen) chk("m0_index_seen", 0, 1);

        preload(359999);
        for (int i = 0; i < 4; i++) step();
        chk("wrap_hour", dut.dig_q, 32'h0100_0000);

        preload(35999999);
        for (int i = 0; i < 4; i++) step();
        chk("full_rollover", dut.dig_q, 32'h0000_0000);
        chk("model_rollover", m_cs, 0);
        for (int i = 0; i < 16; i++) step();

        preload(347);
        step();
        step();
        rst = 1'b1;
        step();
        chk("midreset_dig", dut.dig_q, 32'h0);
        chk("midreset_an", {24'd0, AN}, 32'h0000_00FE);
        chk("midreset_cat", {25'd0, CAT}, 32'h0000_0040);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("no_early_tick", dut.dig_q, 32'h0);
        step();
        chk("first_tick_4", dut.dig_q, 32'h1);
        for (int i = 0; i < 40; i++) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
